// File: rtl/cpu7_ifu_ibr_pkg.sv
// Shared definitions for the IFU instruction bridge: FSM states, widths,
// default window and exception constants, and small address helpers.
package cpu7_ifu_ibr_pkg;

  localparam int SLOT_W  = 32;
  localparam int NSLOT   = 4;
  localparam int GROUP_W = SLOT_W * NSLOT;

  localparam logic [31:0] DEF_UNC_BASE    = 32'h1c00_0000;
  localparam logic [31:0] DEF_UNC_MASK    = 32'hff00_0000;
  localparam logic [5:0]  DEF_ADEF_CODE   = 6'h08;
  localparam logic [5:0]  DEF_BUSERR_CODE = 6'h0a;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } ibr_state_e;

  // Words from the given word index up to the end of the 16-byte line (1..4).
  function automatic logic [2:0] words_to_line_end(input logic [1:0] word_idx);
    return 3'd4 - {1'b0, word_idx};
  endfunction

endpackage

// File: rtl/cpu7_ifu_ibr_chk.sv
// Protocol checker: memory beats may only arrive while a read is outstanding.
module cpu7_ifu_ibr_chk (
  input logic clock,
  input logic resetn,
  input logic i_rvalid,
  input logic i_beat_window
);

  a_rvalid_in_window: assert property (
    @(posedge clock) disable iff (!resetn) i_rvalid |-> i_beat_window
  ) else $error("mem_rvalid outside ISSUE/WAIT/DRAIN");

endmodule

// File: rtl/cpu7_ifu_ibr_pack.sv
// Fetch-group packer: four 32-bit slots filled in return order, plus the
// received-beat counter. Slots are cleared on accept so unused ones read 0.
module cpu7_ifu_ibr_pack
  import cpu7_ifu_ibr_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               i_clear,
  input  logic               i_beat_en,
  input  logic               i_wr_en,
  input  logic [SLOT_W-1:0]  i_wdata,
  output logic [2:0]         o_received,
  output logic [GROUP_W-1:0] o_group
);

  logic [SLOT_W-1:0] r_slot [NSLOT];
  logic [2:0]        r_received;

  // Slot storage and beat counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_received <= 3'd0;
      for (int k = 0; k < NSLOT; k++) r_slot[k] <= '0;
    end else if (i_clear) begin
      r_received <= 3'd0;
      for (int k = 0; k < NSLOT; k++) r_slot[k] <= '0;
    end else begin
      if (i_beat_en) r_received <= r_received + 3'd1;
      if (i_wr_en)   r_slot[r_received[1:0]] <= i_wdata;
    end
  end

  // Flatten slots into the group bus, slot k at bits [32k+31:32k].
  always_comb begin
    o_group = '0;
    for (int k = 0; k < NSLOT; k++) o_group[k*SLOT_W +: SLOT_W] = r_slot[k];
  end

  assign o_received = r_received;

endmodule

// File: rtl/cpu7_ifu_ibr.sv
// IFU-side instruction bridge: accepts one fetch, issues up to four word
// reads to the end of the line, packs the beats and returns one group.
module cpu7_ifu_ibr
  import cpu7_ifu_ibr_pkg::*;
#(
  parameter logic [31:0] UNC_BASE    = DEF_UNC_BASE,
  parameter logic [31:0] UNC_MASK    = DEF_UNC_MASK,
  parameter logic [5:0]  ADEF_CODE   = DEF_ADEF_CODE,
  parameter logic [5:0]  BUSERR_CODE = DEF_BUSERR_CODE
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               inst_req,
  input  logic [31:0]        inst_addr,
  output logic               inst_addr_ok,
  input  logic               inst_cancel,
  output logic               inst_valid,
  output logic [GROUP_W-1:0] inst_rdata,
  output logic [1:0]         inst_count,
  output logic               inst_ex,
  output logic [5:0]         inst_exccode,
  output logic               inst_uncache,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_rerr
);

  ibr_state_e  r_state, w_state_nxt;
  logic [31:2] r_addr;
  logic [2:0]  r_need, r_issued;
  logic [1:0]  r_count;
  logic        r_err, r_misal, r_uncache;

  logic        w_accept, w_misal_in, w_in_flight, w_beat, w_grant;
  logic [2:0]  w_received, w_issued_nxt, w_recv_nxt;
  logic [5:0]  w_exccode;

  assign w_accept     = inst_req & (r_state == ST_IDLE) & ~inst_cancel;
  assign w_misal_in   = |inst_addr[1:0];
  assign w_in_flight  = (r_state == ST_ISSUE) | (r_state == ST_WAIT);
  assign w_beat       = mem_rvalid & (w_in_flight | (r_state == ST_DRAIN));
  // A grant racing a cancel is still a read the memory will answer.
  assign w_grant      = mem_gnt & (r_state == ST_ISSUE);
  assign w_issued_nxt = r_issued + {2'b00, w_grant};
  assign w_recv_nxt   = w_received + {2'b00, w_beat};

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_misal_in ? ST_RESP : ST_ISSUE;
        else          w_state_nxt = ST_IDLE;
      end
      ST_ISSUE: begin
        if (inst_cancel)                w_state_nxt = ST_DRAIN;
        else if (w_recv_nxt == r_need)  w_state_nxt = ST_RESP;
        else if (w_issued_nxt == r_need) w_state_nxt = ST_WAIT;
        else                            w_state_nxt = ST_ISSUE;
      end
      ST_WAIT: begin
        if (inst_cancel)               w_state_nxt = ST_DRAIN;
        else if (w_recv_nxt == r_need) w_state_nxt = ST_RESP;
        else                           w_state_nxt = ST_WAIT;
      end
      ST_RESP:  w_state_nxt = ST_IDLE;
      ST_DRAIN: begin
        if (w_recv_nxt == r_issued) w_state_nxt = ST_IDLE;
        else                        w_state_nxt = ST_DRAIN;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, latched request attributes and issue bookkeeping.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_need    <= 3'd0;
      r_issued  <= 3'd0;
      r_count   <= 2'd0;
      r_err     <= 1'b0;
      r_misal   <= 1'b0;
      r_uncache <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr    <= inst_addr[31:2];
        r_need    <= words_to_line_end(inst_addr[3:2]);
        r_count   <= w_misal_in ? 2'd0 : (2'd3 - inst_addr[3:2]);
        r_uncache <= ((inst_addr & UNC_MASK) == UNC_BASE);
        r_misal   <= w_misal_in;
        r_issued  <= 3'd0;
        r_err     <= 1'b0;
      end else begin
        if (w_grant) r_issued <= w_issued_nxt;
        if (mem_rvalid & mem_rerr & w_in_flight) r_err <= 1'b1;
      end
    end
  end

  // Exception code: alignment fault outranks a bus error.
  always_comb begin
    w_exccode = 6'h00;
    if (r_misal)    w_exccode = ADEF_CODE;
    else if (r_err) w_exccode = BUSERR_CODE;
    else            w_exccode = 6'h00;
  end

  cpu7_ifu_ibr_pack u_pack (
    .clock      (clock),
    .resetn     (resetn),
    .i_clear    (w_accept),
    .i_beat_en  (w_beat),
    .i_wr_en    (mem_rvalid & w_in_flight),
    .i_wdata    (mem_rdata),
    .o_received (w_received),
    .o_group    (inst_rdata)
  );

  cpu7_ifu_ibr_chk u_chk (
    .clock         (clock),
    .resetn        (resetn),
    .i_rvalid      (mem_rvalid),
    .i_beat_window (w_in_flight | (r_state == ST_DRAIN))
  );

  assign inst_addr_ok = w_accept;
  assign inst_valid   = (r_state == ST_RESP) & ~inst_cancel;
  assign inst_count   = r_count;
  assign inst_ex      = r_misal | r_err;
  assign inst_exccode = w_exccode;
  assign inst_uncache = r_uncache;
  assign mem_req      = (r_state == ST_ISSUE) & ~inst_cancel;
  assign mem_addr     = {r_addr[31:4], r_addr[3:2] + r_issued[1:0], 2'b00};

endmodule

// File: tb/tb_cpu7_ifu_ibr.sv
// Bench for cpu7_ifu_ibr: behavioural memory with configurable latency and
// grant rate, expected groups derived directly from the fetch address.
module tb_cpu7_ifu_ibr;

  logic         clock = 1'b0;
  logic         resetn;
  logic         inst_req, inst_cancel, inst_addr_ok, inst_valid, inst_ex, inst_uncache;
  logic [31:0]  inst_addr;
  logic [127:0] inst_rdata;
  logic [1:0]   inst_count;
  logic [5:0]   inst_exccode;
  logic         mem_req, mem_gnt, mem_rvalid, mem_rerr;
  logic [31:0]  mem_addr, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Memory model state: in-order outstanding reads.
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          q_idx[$];
  int          q_gen[$];

  // Observations of the last run_fetch.
  logic [31:0]  obs_maddr[$];
  int           obs_acc_cyc, obs_acc2_cyc, obs_valid_cyc, obs_valid_n, obs_early_valid;
  int           obs_mreq_n, obs_drained, obs_last_drain_cyc, obs_last_beat_cyc;
  bit           obs_timeout, obs_cancel_mreq, obs_ex, obs_unc;
  logic [127:0] obs_rdata;
  logic [1:0]   obs_count;
  logic [5:0]   obs_code;

  cpu7_ifu_ibr dut (
    .clock(clock), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_cancel(inst_cancel), .inst_valid(inst_valid), .inst_rdata(inst_rdata),
    .inst_count(inst_count), .inst_ex(inst_ex), .inst_exccode(inst_exccode),
    .inst_uncache(inst_uncache), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int exp_words(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 0;
    return 4 - int'(a[3:2]);
  endfunction

  function automatic logic [127:0] exp_group(input logic [31:0] a);
    logic [127:0] g;
    g = '0;
    for (int k = 0; k < exp_words(a); k++) g[32*k +: 32] = mem_word(a + 32'(4*k));
    return g;
  endfunction

  function automatic bit exp_unc(input logic [31:0] a);
    return (a[31:24] == 8'h1c);
  endfunction

  // Drive one fetch (optionally cancelled and followed by a second request a2).
  // cmode 0: none; 1: cancel once ck grants issued; 2: cancel ck cycles after accept.
  task automatic run_fetch(input logic [31:0] a1, input logic [31:0] a2, input int lat,
                           input int pct, input int err_beat, input int cmode,
                           input int ck, input int budget);
    bit acc1, acc2, cancelled, fin;
    int ngr, gen, g, idx;
    logic [31:0] qa;
    acc1 = 0; acc2 = 0; cancelled = 0; fin = 0; ngr = 0; gen = 0;
    obs_maddr.delete(); q_addr.delete(); q_due.delete(); q_idx.delete(); q_gen.delete();
    obs_acc_cyc = -1; obs_acc2_cyc = -1; obs_valid_cyc = -1; obs_valid_n = 0;
    obs_early_valid = 0; obs_mreq_n = 0; obs_drained = 0; obs_last_drain_cyc = -1;
    obs_last_beat_cyc = -1; obs_timeout = 0; obs_cancel_mreq = 1'b1;
    obs_rdata = '0; obs_count = 2'd0; obs_code = 6'd0; obs_ex = 0; obs_unc = 0;
    for (int i = 0; i < budget && !fin; i++) begin
      @(negedge clock);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = 32'h0;
      inst_addr   = cancelled ? a2 : a1;
      inst_req    = !acc1 || (cancelled && !acc2);
      inst_cancel = 1'b0;
      if (acc1 && !cancelled && cmode == 1 && ngr == ck) inst_cancel = 1'b1;
      if (acc1 && !cancelled && cmode == 2 && cyc == obs_acc_cyc + ck) inst_cancel = 1'b1;
      #1;
      if (inst_cancel) obs_cancel_mreq = mem_req;
      if (inst_addr_ok) begin
        if (!acc1) begin acc1 = 1; obs_acc_cyc = cyc; end
        else begin acc2 = 1; obs_acc2_cyc = cyc; ngr = 0; gen = 1; end
      end
      if (mem_req) obs_mreq_n++;
      if (mem_req && $urandom_range(99) < pct) begin
        mem_gnt = 1'b1;
        obs_maddr.push_back(mem_addr);
        q_addr.push_back(mem_addr); q_due.push_back(cyc + lat);
        q_idx.push_back(ngr); q_gen.push_back(gen);
        ngr++;
      end
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        qa = q_addr.pop_front(); void'(q_due.pop_front());
        idx = q_idx.pop_front(); g = q_gen.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(qa);
        mem_rerr   = (g == 0 && idx == err_beat);
        obs_last_beat_cyc = cyc;
        if (g == 0 && cancelled) begin obs_drained++; obs_last_drain_cyc = cyc; end
      end
      #1;
      if (inst_valid) begin
        obs_valid_n++; obs_valid_cyc = cyc;
        obs_rdata = inst_rdata; obs_count = inst_count; obs_ex = inst_ex;
        obs_code = inst_exccode; obs_unc = inst_uncache;
        if (cmode != 0 && !acc2) obs_early_valid++;
      end else if (obs_valid_n > 0) begin
        fin = 1;
      end
      if (inst_cancel) cancelled = 1;
      if (!fin) @(posedge clock);
    end
    if (!fin) obs_timeout = 1;
    inst_req = 1'b0; inst_cancel = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rerr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock); #1;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_checks++; if (inst_ex !== 1'b0) begin n_fail++; $display("FAIL reset_ex: got %b want 0", inst_ex); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++; if (inst_rdata !== 128'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", inst_rdata); end
    n_checks++; if (inst_count !== 2'd0 || inst_exccode !== 6'd0) begin n_fail++; $display("FAIL reset_count_code: got %0d/%h want 0/0", inst_count, inst_exccode); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; #1;
    n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL idle_addr_ok: got %b want 1", inst_addr_ok); end
    inst_cancel = 1'b1; #1;
    n_checks++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL cancel_blocks_ok: got %b want 0", inst_addr_ok); end
    inst_req = 1'b0; inst_cancel = 1'b0;
    @(negedge clock); resetn = 1'b1;
  endtask

  task automatic test_aligned_uncached();
    run_fetch(32'h1c00_0000, 32'h0, 1, 100, -1, 0, 0, 100);
    n_checks++; if (obs_timeout || obs_valid_n !== 1) begin n_fail++; $display("FAIL aligned_pulse: got %0d pulses timeout=%0d want 1", obs_valid_n, obs_timeout); end
    n_checks++; if (obs_maddr.size() !== 4) begin n_fail++; $display("FAIL aligned_nreq: got %0d want 4", obs_maddr.size()); end
    for (int k = 0; k < 4 && k < obs_maddr.size(); k++) begin
      n_checks++; if (obs_maddr[k] !== 32'h1c00_0000 + 32'(4*k)) begin n_fail++; $display("FAIL aligned_addr%0d: got %h want %h", k, obs_maddr[k], 32'h1c00_0000 + 32'(4*k)); end
    end
    n_checks++; if (obs_rdata !== exp_group(32'h1c00_0000)) begin n_fail++; $display("FAIL aligned_rdata: got %h want %h", obs_rdata, exp_group(32'h1c00_0000)); end
    n_checks++; if (obs_count !== 2'd3 || obs_unc !== 1'b1 || obs_ex !== 1'b0) begin n_fail++; $display("FAIL aligned_attr: got cnt %0d unc %0d ex %0d want 3 1 0", obs_count, obs_unc, obs_ex); end
    n_checks++; if (obs_valid_cyc - obs_acc_cyc !== 6) begin n_fail++; $display("FAIL aligned_latency: got %0d want 6", obs_valid_cyc - obs_acc_cyc); end
  endtask

  task automatic test_partial_line();
    run_fetch(32'h8000_0008, 32'h0, 1, 100, -1, 0, 0, 100);
    n_checks++; if (obs_timeout || obs_valid_n !== 1) begin n_fail++; $display("FAIL partial_pulse: got %0d want 1", obs_valid_n); end
    n_checks++; if (obs_maddr.size() !== 2) begin n_fail++; $display("FAIL partial_nreq: got %0d want 2", obs_maddr.size()); end
    n_checks++; if (obs_rdata !== exp_group(32'h8000_0008) || obs_rdata[127:64] !== 64'h0) begin n_fail++; $display("FAIL partial_rdata: got %h want %h", obs_rdata, exp_group(32'h8000_0008)); end
    n_checks++; if (obs_count !== 2'd1 || obs_unc !== 1'b0) begin n_fail++; $display("FAIL partial_attr: got cnt %0d unc %0d want 1 0", obs_count, obs_unc); end
  endtask

  task automatic test_misaligned();
    run_fetch(32'h8000_0006, 32'h0, 1, 100, -1, 0, 0, 50);
    n_checks++; if (obs_mreq_n !== 0) begin n_fail++; $display("FAIL misal_no_mem: got %0d req cycles want 0", obs_mreq_n); end
    n_checks++; if (obs_timeout || obs_valid_cyc - obs_acc_cyc !== 1) begin n_fail++; $display("FAIL misal_latency: got %0d want 1", obs_valid_cyc - obs_acc_cyc); end
    n_checks++; if (obs_ex !== 1'b1 || obs_code !== 6'h08 || obs_count !== 2'd0) begin n_fail++; $display("FAIL misal_ex: got ex %0d code %h cnt %0d want 1 08 0", obs_ex, obs_code, obs_count); end
    n_checks++; if (obs_rdata !== 128'h0) begin n_fail++; $display("FAIL misal_rdata: got %h want 0", obs_rdata); end
  endtask

  task automatic test_cancel_drain();
    run_fetch(32'h1c00_0040, 32'h8000_0100, 3, 100, -1, 1, 2, 200);
    n_checks++; if (obs_cancel_mreq !== 1'b0) begin n_fail++; $display("FAIL drain_req_drop: got %b want 0", obs_cancel_mreq); end
    n_checks++; if (obs_drained !== 2) begin n_fail++; $display("FAIL drain_beats: got %0d want 2", obs_drained); end
    n_checks++; if (obs_early_valid !== 0) begin n_fail++; $display("FAIL drain_no_valid: got %0d want 0", obs_early_valid); end
    n_checks++; if (obs_acc2_cyc !== obs_last_drain_cyc + 1) begin n_fail++; $display("FAIL drain_reaccept: got %0d want %0d", obs_acc2_cyc, obs_last_drain_cyc + 1); end
    n_checks++; if (obs_maddr.size() !== 6) begin n_fail++; $display("FAIL drain_nreq: got %0d want 6", obs_maddr.size()); end
    n_checks++; if (obs_timeout || obs_rdata !== exp_group(32'h8000_0100)) begin n_fail++; $display("FAIL drain_next_rdata: got %h want %h", obs_rdata, exp_group(32'h8000_0100)); end
  endtask

  task automatic test_bus_error();
    run_fetch(32'h8000_0010, 32'h0, 2, 100, 1, 0, 0, 100);
    n_checks++; if (obs_timeout || obs_ex !== 1'b1 || obs_code !== 6'h0a) begin n_fail++; $display("FAIL buserr_ex: got ex %0d code %h want 1 0a", obs_ex, obs_code); end
    n_checks++; if (obs_valid_cyc - obs_acc_cyc !== 7 || obs_valid_cyc <= obs_last_beat_cyc) begin n_fail++; $display("FAIL buserr_latency: got %0d want 7", obs_valid_cyc - obs_acc_cyc); end
    n_checks++; if (obs_rdata !== exp_group(32'h8000_0010)) begin n_fail++; $display("FAIL buserr_rdata: got %h want %h", obs_rdata, exp_group(32'h8000_0010)); end
  endtask

  task automatic test_cancel_resp();
    run_fetch(32'h8000_000c, 32'h1c00_0020, 1, 100, -1, 2, 3, 100);
    n_checks++; if (obs_early_valid !== 0) begin n_fail++; $display("FAIL respcan_no_valid: got %0d want 0", obs_early_valid); end
    n_checks++; if (obs_acc2_cyc !== obs_acc_cyc + 4) begin n_fail++; $display("FAIL respcan_reaccept: got %0d want %0d", obs_acc2_cyc - obs_acc_cyc, 4); end
    n_checks++; if (obs_timeout || obs_rdata !== exp_group(32'h1c00_0020) || obs_ex !== 1'b0) begin n_fail++; $display("FAIL respcan_next: got %h ex %0d want %h ex 0", obs_rdata, obs_ex, exp_group(32'h1c00_0020)); end
  endtask

  task automatic test_back_to_back();
    run_fetch(32'h8000_000c, 32'h0, 0, 100, -1, 0, 0, 50);
    n_checks++; if (obs_timeout || obs_valid_cyc - obs_acc_cyc !== 2) begin n_fail++; $display("FAIL b2b_lat1: got %0d want 2", obs_valid_cyc - obs_acc_cyc); end
    n_checks++; if (obs_rdata !== exp_group(32'h8000_000c) || obs_count !== 2'd0) begin n_fail++; $display("FAIL b2b_rdata1: got %h want %h", obs_rdata, exp_group(32'h8000_000c)); end
    run_fetch(32'h8000_0028, 32'h0, 0, 100, -1, 0, 0, 50);
    n_checks++; if (obs_timeout || obs_valid_cyc - obs_acc_cyc !== 3) begin n_fail++; $display("FAIL b2b_lat2: got %0d want 3", obs_valid_cyc - obs_acc_cyc); end
    n_checks++; if (obs_rdata !== exp_group(32'h8000_0028) || obs_count !== 2'd1) begin n_fail++; $display("FAIL b2b_rdata2: got %h want %h", obs_rdata, exp_group(32'h8000_0028)); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int lat, pct, e, n;
    bit want_ex;
    for (int it = 0; it < 10; it++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[31:24] = 8'h1c;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      lat = $urandom_range(0, 3);
      pct = $urandom_range(30, 100);
      e   = $urandom_range(0, 6);
      n   = exp_words(a);
      if (e >= 4) e = -1;
      want_ex = (n == 0) || (e >= 0 && e < n);
      run_fetch(a, 32'h0, lat, pct, e, 0, 0, 300);
      n_checks++; if (obs_timeout || obs_valid_n !== 1) begin n_fail++; $display("FAIL rnd%0d_pulse: got %0d want 1 (addr %h)", it, obs_valid_n, a); end
      n_checks++; if (obs_maddr.size() !== n) begin n_fail++; $display("FAIL rnd%0d_nreq: got %0d want %0d", it, obs_maddr.size(), n); end
      for (int k = 0; k < n && k < obs_maddr.size(); k++) begin
        n_checks++; if (obs_maddr[k] !== a + 32'(4*k)) begin n_fail++; $display("FAIL rnd%0d_addr%0d: got %h want %h", it, k, obs_maddr[k], a + 32'(4*k)); end
      end
      n_checks++; if (obs_rdata !== exp_group(a)) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", it, obs_rdata, exp_group(a)); end
      n_checks++; if (obs_count !== ((n == 0) ? 2'd0 : 2'(n - 1)) || obs_unc !== exp_unc(a)) begin n_fail++; $display("FAIL rnd%0d_attr: got cnt %0d unc %0d (addr %h)", it, obs_count, obs_unc, a); end
      n_checks++; if (obs_ex !== want_ex) begin n_fail++; $display("FAIL rnd%0d_ex: got %0d want %0d", it, obs_ex, want_ex); end
      if (want_ex) begin
        n_checks++; if (obs_code !== ((n == 0) ? 6'h08 : 6'h0a)) begin n_fail++; $display("FAIL rnd%0d_code: got %h want %h", it, obs_code, (n == 0) ? 6'h08 : 6'h0a); end
      end
    end
  endtask

  initial begin
    resetn = 1'b0; inst_req = 1'b0; inst_cancel = 1'b0; inst_addr = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rerr = 1'b0;
    repeat (2) @(posedge clock);
    test_reset();
    test_aligned_uncached();
    test_partial_line();
    test_misaligned();
    test_cancel_drain();
    test_bus_error();
    test_cancel_resp();
    test_back_to_back();
    test_random();
    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
